mine_placer: RTL and testbench



---
 rtl/ms_pkg.sv | 17 +
 rtl/lfsr16.sv | 24 ++
 rtl/mine_placer.sv | 152 +++++++++++++++
 tb/tb_mine_placer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_pkg.sv
// Shared minesweeper definitions: board geometry, LFSR constants and placer states.
// Used by the mine placer, the game datapath and the display logic.
package ms_pkg;
    localparam int CELLS = 25;
    localparam int POS_W = 5;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAW,
        FILL,
        DONE
    } placer_state_e;
endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous reset, parallel load and advance enable.
module lfsr16
    import ms_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = ms_pkg::SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic [15:0] q
);
    // Load wins over advance so a new seed is never shifted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end
endmodule

// File: rtl/mine_placer.sv
// Generates a NUM_MINES-mine mask for the 5x5 board: random LFSR draws, then lowest-free fill.
// Build option SAFE_CELL_EN adds a safe_cell input naming a cell that never receives a mine.
module mine_placer
    import ms_pkg::*;
#(
    parameter int          NUM_MINES    = 5,
    parameter int          MAX_TRIES    = 64,
    parameter logic [15:0] SEED_DEFAULT = ms_pkg::SEED_DEFAULT
) (
    input  logic                clka,
    input  logic                restart,
    input  logic                start,
    input  logic [15:0]         seed,
`ifdef SAFE_CELL_EN
    input  logic [POS_W-1:0]    safe_cell,
`endif
    output logic [CELLS-1:0]    mines,
    output logic                place_done,
    output logic                busy,
    output logic [POS_W-1:0]    mine_cnt,
    output placer_state_e       state
);
    // Handshake: start is a request level sampled only in IDLE/DONE; place_done is a
    // status level that stays high, with mines stable, until the next accepted start.

    if (NUM_MINES < 0 || NUM_MINES >= CELLS) begin : g_bad_num_mines
        $error("mine_placer: NUM_MINES out of range 0..CELLS-1");
    end
    if (MAX_TRIES < 0) begin : g_bad_max_tries
        $error("mine_placer: MAX_TRIES must be non-negative");
    end

    localparam int TRY_W = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

    function automatic logic [POS_W-1:0] lowest_free(input logic [CELLS-1:0] taken);
        logic [POS_W-1:0] idx;
        idx = '0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (!taken[i]) idx = POS_W'(i);
        end
        return idx;
    endfunction

    placer_state_e     state_n;
    logic [CELLS-1:0]  mines_n;
    logic [POS_W-1:0]  cnt_n;
    logic [TRY_W-1:0]  tries_q;
    logic [TRY_W-1:0]  tries_n;
    logic              lfsr_load;
    logic              lfsr_en;
    logic [15:0]       lfsr_q;
    logic [15:0]       load_val;
    logic [POS_W-1:0]  cand;
    logic [31:0]       blocked;
    logic [CELLS-1:0]  safe_mask;
    logic              accept;
    logic              unused_lfsr_hi;

    assign unused_lfsr_hi = ^lfsr_q[15:POS_W];
    assign load_val       = (seed == 16'h0000) ? SEED_DEFAULT : seed;
    assign cand           = lfsr_q[POS_W-1:0];

`ifdef SAFE_CELL_EN
    logic [POS_W-1:0] safe_q;

    always_ff @(posedge clka) begin
        if (restart) begin
            safe_q <= '1;
        end else if (lfsr_load) begin
            safe_q <= safe_cell;
        end
    end

    // Out-of-board safe_cell values exclude nothing.
    assign safe_mask = (safe_q < POS_W'(CELLS)) ? (CELLS'(1) << safe_q) : '0;
`else
    assign safe_mask = '0;
`endif

    // Codes 25..31 are permanently blocked so they count as tries but never place.
    assign blocked = {{(32 - CELLS){1'b1}}, mines | safe_mask};
    assign accept  = !blocked[cand];

    lfsr16 #(
        .RESET_VAL (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clka),
        .rst      (restart),
        .load     (lfsr_load),
        .load_val (load_val),
        .en       (lfsr_en),
        .q        (lfsr_q)
    );

    always_comb begin
        state_n   = state;
        mines_n   = mines;
        cnt_n     = mine_cnt;
        tries_n   = tries_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = LOAD;
                    lfsr_load = 1'b1;
                end
            end
            LOAD: begin
                mines_n = '0;
                cnt_n   = '0;
                tries_n = '0;
                if (NUM_MINES == 0)      state_n = DONE;
                else if (MAX_TRIES == 0) state_n = FILL;
                else                     state_n = DRAW;
            end
            DRAW: begin
                lfsr_en = 1'b1;
                tries_n = tries_q + TRY_W'(1);
                if (accept) begin
                    mines_n = mines | (CELLS'(1) << cand);
                    cnt_n   = mine_cnt + POS_W'(1);
                end
                if (cnt_n == POS_W'(NUM_MINES))      state_n = DONE;
                else if (tries_n == TRY_W'(MAX_TRIES)) state_n = FILL;
            end
            FILL: begin
                mines_n = mines | (CELLS'(1) << lowest_free(mines | safe_mask));
                cnt_n   = mine_cnt + POS_W'(1);
                if (cnt_n == POS_W'(NUM_MINES)) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state    <= IDLE;
            mines    <= '0;
            mine_cnt <= '0;
            tries_q  <= '0;
        end else begin
            state    <= state_n;
            mines    <= mines_n;
            mine_cnt <= cnt_n;
            tries_q  <= tries_n;
        end
    end

    assign place_done = (state == DONE);
    assign busy       = (state == LOAD) || (state == DRAW) || (state == FILL);
endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer: three parameterisations against a procedural placement model.
// Honours SAFE_CELL_EN when the design is built with it.
module tb_mine_placer;
    import ms_pkg::*;

    logic        clk;
    logic        restart;
    logic [15:0] seed;
    logic        start_a, start_b, start_c;
`ifdef SAFE_CELL_EN
    logic [4:0]  safe;
`endif

    logic [24:0]   mines_a, mines_b, mines_c;
    logic          done_a, done_b, done_c;
    logic          busy_a, busy_b, busy_c;
    logic [4:0]    cnt_a, cnt_b, cnt_c;
    placer_state_e st_a, st_b, st_c;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mine_placer #(.NUM_MINES(5), .MAX_TRIES(64)) u_a (
        .clka(clk), .restart(restart), .start(start_a), .seed(seed),
`ifdef SAFE_CELL_EN
        .safe_cell(safe),
`endif
        .mines(mines_a), .place_done(done_a), .busy(busy_a), .mine_cnt(cnt_a), .state(st_a)
    );

    mine_placer #(.NUM_MINES(5), .MAX_TRIES(0)) u_b (
        .clka(clk), .restart(restart), .start(start_b), .seed(seed),
`ifdef SAFE_CELL_EN
        .safe_cell(safe),
`endif
        .mines(mines_b), .place_done(done_b), .busy(busy_b), .mine_cnt(cnt_b), .state(st_b)
    );

    mine_placer #(.NUM_MINES(0), .MAX_TRIES(64)) u_c (
        .clka(clk), .restart(restart), .start(start_c), .seed(seed),
`ifdef SAFE_CELL_EN
        .safe_cell(safe),
`endif
        .mines(mines_c), .place_done(done_c), .busy(busy_c), .mine_cnt(cnt_c), .state(st_c)
    );

    // ---------------- reference model ----------------
    // Plays the placement rules out draw by draw; lat counts edges from the
    // accepting edge through the edge that enters DONE, inclusive.
    function automatic void model(input logic [15:0] s, input int num, input int maxt,
                                  input int sc, output logic [24:0] m, output int lat);
        logic [15:0] l;
        int c, cnt, t;
        l   = (s == 16'h0000) ? 16'hACE1 : s;
        m   = '0;
        cnt = 0;
        t   = 0;
        lat = 2;
        if (num == 0) return;
        if (maxt > 0) begin
            forever begin
                c = int'(l % 16'd32);
                if (c < 25 && c != sc) begin
                    if (m[c] == 1'b0) begin
                        m[c] = 1'b1;
                        cnt++;
                    end
                end
                l = (l >> 1) ^ ((l % 16'd2 == 16'd1) ? 16'hB400 : 16'h0000);
                t++;
                lat++;
                if (cnt == num || t == maxt) break;
            end
        end
        while (cnt < num) begin
            for (int i = 0; i < 25; i++) begin
                if (m[i] == 1'b0 && i != sc) begin
                    m[i] = 1'b1;
                    break;
                end
            end
            cnt++;
            lat++;
        end
    endfunction

    function automatic int eff_safe(input logic [4:0] sc);
`ifdef SAFE_CELL_EN
        return int'(sc);
`else
        return 31 + 0 * int'(sc);
`endif
    endfunction

    // ---------------- scoreboard / checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic [24:0] get_mines(input int sel);
        case (sel)
            0: return mines_a;
            1: return mines_b;
            default: return mines_c;
        endcase
    endfunction

    task automatic run(input int sel, input logic [15:0] s, input logic [4:0] sc,
                       output logic [24:0] m, output int lat);
        int k;
        @(negedge clk);
        seed = s;
`ifdef SAFE_CELL_EN
        safe = sc;
`endif
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (get_done(sel)) break;
        end
        if (!get_done(sel)) check("run_timeout", 32'(get_done(sel)), 32'd1);
        lat = k + 1;
        m   = get_mines(sel);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [24:0] m, m2, em;
        logic [15:0] s;
        logic [4:0]  sc;
        int lat, elat, low;

        restart = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        seed    = 16'h0000;
`ifdef SAFE_CELL_EN
        safe    = 5'd31;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_mines_a", 32'(mines_a), 32'd0);
        check("rst_done_a",  32'(done_a),  32'd0);
        check("rst_busy_a",  32'(busy_a),  32'd0);
        check("rst_cnt_a",   32'(cnt_a),   32'd0);
        check("rst_state_a", 32'(st_a),    32'(IDLE));
        check("rst_state_b", 32'(st_b),    32'(IDLE));
        check("rst_state_c", 32'(st_c),    32'(IDLE));
        check("rst_mines_b", 32'(mines_b), 32'd0);
        @(negedge clk);
        restart = 1'b0;

        // Fill-only placer: lowest free cells, fixed latency.
`ifdef SAFE_CELL_EN
        run(1, 16'h1234, 5'd2, m, lat);
        check("fill_safe_mask", 32'(m), 32'h0000003B);
        check("fill_safe_bit2", 32'(m[2]), 32'd0);
`else
        run(1, 16'h1234, 5'd31, m, lat);
        check("fill_mask", 32'(m), 32'h0000001F);
`endif
        check("fill_latency", 32'(lat), 32'd7);
        check("fill_cnt", 32'(cnt_b), 32'd5);
        for (int i = 0; i < 6; i++) begin
            s  = 16'($urandom);
            sc = 5'($urandom_range(0, 31));
            run(1, s, sc, m, lat);
            model(s, 5, 0, eff_safe(sc), em, elat);
            check("fill_rand_mask", 32'(m), 32'(em));
            check("fill_rand_lat", 32'(lat), 32'(elat));
        end

        // Zero-mine placer.
        run(2, 16'h0042, 5'd3, m, lat);
        check("zero_mask", 32'(m), 32'd0);
        check("zero_latency", 32'(lat), 32'd2);

        // Random draws, seeds 1..1000.
        for (int i = 1; i <= 1000; i++) begin
            s  = 16'(i);
            sc = 5'($urandom_range(0, 31));
            run(0, s, sc, m, lat);
            model(s, 5, 64, eff_safe(sc), em, elat);
            check("draw_mask", 32'(m), 32'(em));
            check("draw_popcount", 32'($countones(m)), 32'd5);
            check("draw_lat", 32'(lat), 32'(elat));
            check("draw_lat_bound", 32'(lat <= 71), 32'd1);
            check("draw_cnt", 32'(cnt_a), 32'd5);
        end

        // Seed 0 selects the default seed; repeated seeds repeat masks.
        run(0, 16'h0000, 5'd31, m, lat);
        run(0, 16'hACE1, 5'd31, m2, lat);
        model(16'hACE1, 5, 64, 31, em, elat);
        check("seed0_vs_default", 32'(m), 32'(m2));
        check("seed0_model", 32'(m), 32'(em));
        s  = 16'($urandom_range(1, 65535));
        sc = 5'($urandom_range(0, 31));
        run(0, s, sc, m, lat);
        run(0, s, sc, m2, lat);
        check("same_seed_repeat", 32'(m2), 32'(m));

        // start held through busy and DONE: one run per DONE, new seed picked up.
        @(negedge clk);
        s = 16'h5A5A;
        seed = s;
`ifdef SAFE_CELL_EN
        safe = 5'd31;
`endif
        start_a = 1'b1;
        @(posedge clk);
        #1;
        low = 0;
        while (low < 200 && !done_a) begin
            @(posedge clk);
            #1;
            low++;
        end
        model(s, 5, 64, 31, em, elat);
        check("held_first_mask", 32'(mines_a), 32'(em));
        check("held_first_lat", 32'(low + 1), 32'(elat));
        s = 16'h0F0F;
        seed = s;
        model(s, 5, 64, 31, em, elat);
        low = 0;
        forever begin
            @(posedge clk);
            #1;
            if (done_a || low >= 200) break;
            low++;
        end
        check("held_low_2plus", 32'(low >= 2), 32'd1);
        check("held_low_len", 32'(low), 32'(elat - 1));
        check("held_second_mask", 32'(mines_a), 32'(em));
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 32'(done_a), 32'd1);
        check("done_mask_stable", 32'(mines_a), 32'(em));

        // restart mid-DRAW.
        @(negedge clk);
        seed = 16'($urandom_range(1, 65535));
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_draw", 32'(st_a), 32'(DRAW));
        @(negedge clk);
        restart = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_mines", 32'(mines_a), 32'd0);
        check("midrst_done",  32'(done_a),  32'd0);
        check("midrst_busy",  32'(busy_a),  32'd0);
        check("midrst_cnt",   32'(cnt_a),   32'd0);
        check("midrst_state", 32'(st_a),    32'(IDLE));
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(st_a), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
